// File: rtl/pico_code_loader.sv
// pico_code_loader: turns a framed byte stream into program-RAM preload writes.
//
// Frame: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, N x {B0, B1, B2}, CSUM.
// The 8-bit sum of every byte after SYNC (CSUM included) must be zero. Writes
// are committed as they arrive. A good checksum toggles remap and pulses
// load_done. A bad checksum or an oversize count sets the sticky load_err.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   rx_data/valid/ready   byte stream in; a byte is consumed on rx_valid & rx_ready
//   inst_address/data_out program RAM write address and 18-bit instruction
//   inst_update           one-cycle RAM write strobe
//   remap                 level, toggles once per verified load
//   busy                  high whenever a frame is in progress
//   load_done             one-cycle pulse on verified load
//   load_err              sticky error, cleared by the next accepted SYNC byte
//
// Optional: define LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES
// cycles without an accepted byte.
module pico_code_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_COUNT      = 1024,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [9:0]  inst_address,
  output logic [17:0] inst_data_out,
  output logic        inst_update,
  output logic        remap,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [3:0] {
    StIdle, StAddrHi, StAddrLo, StCntHi, StCntLo, StB0, StB1, StB2, StWrite, StCsum
  } state_e;

  state_e      state_q;
  logic [9:0]  addr_q;
  logic [10:0] remain_q;
  logic [7:0]  cnt_hi_q;
  logic [1:0]  b0_q;
  logic [7:0]  b1_q;
  logic [7:0]  csum_q;

  logic        accept;
  logic [7:0]  csum_next;
  logic [15:0] count_full;

  // Both flags are pure decodes of the state register.
  assign rx_ready   = (state_q != StWrite);
  assign busy       = (state_q != StIdle);
  assign accept     = rx_valid & rx_ready;
  assign csum_next  = csum_q + rx_data;
  assign count_full = {cnt_hi_q, rx_data};

`ifdef LOADER_TIMEOUT_EN
  logic [23:0] tmo_q;
  logic [23:0] tmo_inc;
  assign tmo_inc = tmo_q + 24'd1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remain_q      <= '0;
      cnt_hi_q      <= '0;
      b0_q          <= '0;
      b1_q          <= '0;
      csum_q        <= '0;
      inst_address  <= '0;
      inst_data_out <= '0;
      inst_update   <= 1'b0;
      remap         <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      inst_update <= 1'b0;
      load_done   <= 1'b0;

      // Every in-frame byte is summed, including unused header/opcode bits.
      if (accept && state_q != StIdle) csum_q <= csum_next;

      case (state_q)
        StIdle: begin
          if (accept && rx_data == SYNC_BYTE) begin
            state_q  <= StAddrHi;
            load_err <= 1'b0;
            csum_q   <= '0;
          end
        end
        StAddrHi: if (accept) begin
          addr_q[9:8] <= rx_data[1:0];
          state_q     <= StAddrLo;
        end
        StAddrLo: if (accept) begin
          addr_q[7:0] <= rx_data;
          state_q     <= StCntHi;
        end
        StCntHi: if (accept) begin
          cnt_hi_q <= rx_data;
          state_q  <= StCntLo;
        end
        StCntLo: if (accept) begin
          if ({16'd0, count_full} > MAX_COUNT) begin
            load_err <= 1'b1;
            state_q  <= StIdle;
          end else if (count_full == 16'd0) begin
            state_q <= StCsum;
          end else begin
            remain_q <= count_full[10:0];
            state_q  <= StB0;
          end
        end
        StB0: if (accept) begin
          b0_q    <= rx_data[1:0];
          state_q <= StB1;
        end
        StB1: if (accept) begin
          b1_q    <= rx_data;
          state_q <= StB2;
        end
        StB2: if (accept) begin
          inst_update   <= 1'b1;
          inst_address  <= addr_q;
          inst_data_out <= {b0_q, b1_q, rx_data};
          state_q       <= StWrite;
        end
        StWrite: begin
          // 10-bit address wraps naturally from 0x3FF to 0x000.
          addr_q   <= addr_q + 10'd1;
          remain_q <= remain_q - 11'd1;
          state_q  <= (remain_q == 11'd1) ? StCsum : StB0;
        end
        StCsum: if (accept) begin
          if (csum_next == 8'h00) begin
            remap     <= ~remap;
            load_done <= 1'b1;
          end else begin
            load_err <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

`ifdef LOADER_TIMEOUT_EN
      // Counter is frozen in WRITE; it is already zero there since B2 was just accepted.
      if (state_q == StIdle || accept) begin
        tmo_q <= '0;
      end else if (state_q != StWrite) begin
        if (tmo_inc == TIMEOUT_CYCLES) begin
          tmo_q    <= '0;
          load_err <= 1'b1;
          state_q  <= StIdle;
        end else begin
          tmo_q <= tmo_inc;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_pico_code_loader.sv
// Self-checking bench for pico_code_loader: directed and random frames checked
// against a frame-level model that parses the byte list directly.
module tb_pico_code_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  inst_address;
  logic [17:0] inst_data_out;
  logic        inst_update;
  logic        remap;
  logic        busy;
  logic        load_done;
  logic        load_err;

  always #5 clk = ~clk;

  pico_code_loader #(
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .inst_address  (inst_address),
    .inst_data_out (inst_data_out),
    .inst_update   (inst_update),
    .remap         (remap),
    .busy          (busy),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  frame_q[$];
  logic [27:0] obs_q[$];
  logic [27:0] exp_q[$];
  int          done_cnt  = 0;
  int          stall_cnt = 0;
  int          exp_n;
  logic        exp_ok;
  logic        exp_err;
  logic        exp_remap = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (inst_update) obs_q.push_back({inst_address, inst_data_out});
    if (load_done) done_cnt++;
  end

  // Reference: parse the frame byte list directly.
  task automatic model_frame();
    int unsigned a, n, s, d;
    logic [27:0] e;
    exp_q.delete();
    exp_n   = 0;
    exp_ok  = 1'b0;
    exp_err = 1'b0;
    a = (int'(frame_q[1]) % 4) * 256 + int'(frame_q[2]);
    n = int'(frame_q[3]) * 256 + int'(frame_q[4]);
    if (n > 1024) begin
      exp_err = 1'b1;
      return;
    end
    s = 0;
    for (int i = 1; i < frame_q.size(); i++) s += int'(frame_q[i]);
    for (int k = 0; k < int'(n); k++) begin
      d = (int'(frame_q[5 + 3 * k]) % 4) * 65536 + int'(frame_q[6 + 3 * k]) * 256
          + int'(frame_q[7 + 3 * k]);
      e[27:18] = 10'((a + k) % 1024);
      e[17:0]  = 18'(d);
      exp_q.push_back(e);
    end
    exp_n   = n;
    exp_ok  = (s % 256 == 0);
    exp_err = !exp_ok;
  endtask

  task automatic build_frame(input logic [9:0] addr, input int n, input logic good);
    logic [7:0] s;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back({6'($urandom), addr[9:8]});
    frame_q.push_back(addr[7:0]);
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    for (int k = 0; k < 3 * n; k++) frame_q.push_back(8'($urandom));
    s = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) s = s + frame_q[i];
    b = 8'h00 - s;
    if (!good) b = b + 8'h01;
    frame_q.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 10) begin
      stall_cnt++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 10) check("rx_ready_stuck_low", 32'(rx_ready), 32'd1);
  endtask

  task automatic start_frame();
    model_frame();
    obs_q.delete();
    done_cnt  = 0;
    stall_cnt = 0;
  endtask

  task automatic finish_frame(input string tag);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_ok) exp_remap = ~exp_remap;
    check({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check({tag, "_wr"}, obs_q[i], exp_q[i]);
    check({tag, "_stalls"}, stall_cnt, exp_n);
    check({tag, "_remap"}, 32'(remap), 32'(exp_remap));
    check({tag, "_err"}, 32'(load_err), 32'(exp_err));
    check({tag, "_done"}, done_cnt, 32'(exp_ok));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input string tag);
    start_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    finish_frame(tag);
  endtask

  task automatic set_frame(input logic [7:0] b[]);
    frame_q.delete();
    foreach (b[i]) frame_q.push_back(b[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fa[];
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(rx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_update", 32'(inst_update), 32'd0);
    check("rst_addr", 32'(inst_address), 32'd0);
    check("rst_data", 32'(inst_data_out), 32'd0);
    check("rst_remap", 32'(remap), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    reset = 1'b0;

    // Garbage before SYNC is ignored.
    send_byte(8'h00); send_byte(8'h11); send_byte(8'hA4);
    @(negedge clk); rx_valid = 1'b0;
    check("garbage_busy", 32'(busy), 32'd0);

    fa = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h03, 8'hFF, 8'hFF, 8'h84};
    set_frame(fa);
    run_frame("good");

    fa = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h03, 8'hFF, 8'hFF, 8'h85};
    set_frame(fa);
    run_frame("badsum");

    // Fresh SYNC clears the error; then reset after first B1 aborts with no write.
    obs_q.delete();
    send_byte(8'hA5);
    @(negedge clk); rx_valid = 1'b0;
    check("sync_clr_err", 32'(load_err), 32'd0);
    check("sync_busy", 32'(busy), 32'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h03); send_byte(8'hCC);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    exp_remap = 1'b0;
    check("midrst_nwr", obs_q.size(), 0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_remap", 32'(remap), 32'd0);
    check("midrst_ready", 32'(rx_ready), 32'd1);

    build_frame(10'h3FF, 2, 1'b1);
    run_frame("wrap");

    fa = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h01};
    set_frame(fa);
    run_frame("ovf");

    build_frame(10'h155, 0, 1'b1);
    run_frame("zero");

    build_frame(10'h200, 1024, 1'b1);
    run_frame("max");

    for (int r = 0; r < 12; r++) begin
      logic [9:0] a;
      a = (r % 4 == 0) ? 10'(1023 - $urandom_range(0, 2)) : 10'($urandom_range(0, 1023));
      build_frame(a, $urandom_range(1, 6), ($urandom_range(0, 3) != 0));
      run_frame("rand");
    end

    // Long stall after CNT_HI.
    build_frame(10'h040, 1, 1'b1);
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(frame_q[i]);
    @(negedge clk); rx_valid = 1'b0;
    repeat (150) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
    check("tmo_err", 32'(load_err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_nwr", obs_q.size(), 0);
    check("tmo_remap", 32'(remap), 32'(exp_remap));
`else
    check("stall_busy", 32'(busy), 32'd1);
    for (int i = 4; i < frame_q.size(); i++) send_byte(frame_q[i]);
    finish_frame("stall");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pico_code_loader.md
Name: pico_code_loader

Overview:
- Upstream feeder of the CPU subsystem's program-RAM preload path.
- Consumes a framed byte stream (from UART RX) and writes 18-bit PicoBlaze instructions into program RAM through the preload interface (`inst_address`, `inst_data_out`, `inst_update`).
- On a checksum-verified frame, toggles the `remap` level so the CPU top switches to the freshly loaded code and issues its reset.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_COUNT, 1024, maximum instructions per frame (program RAM depth).
- TIMEOUT_CYCLES, 24'd1_000_000, inter-byte timeout in clk cycles; used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle
- rx_ready  out  1  loader accepts rx_data when high; byte is consumed when rx_valid & rx_ready
- inst_address  out  10  program RAM write address
- inst_data_out  out  18  program RAM write data
- inst_update  out  1  one-cycle RAM write strobe
- remap  out  1  level; toggles once per successful load
- busy  out  1  high in every state except IDLE
- load_done  out  1  one-cycle pulse on successful load
- load_err  out  1  sticky error; cleared on next accepted SYNC_BYTE

Behaviour:
- Reset: state=IDLE.
  - Outputs: rx_ready=1, inst_update=0, inst_address=0, inst_data_out=0, remap=0, busy=0, load_done=0, load_err=0.
  - Checksum accumulator and counters cleared.
- Frame format, in byte order:
  - SYNC
  - ADDR_HI (bits 1:0 used)
  - ADDR_LO
  - CNT_HI
  - CNT_LO
  - N × {B0 (bits 1:0 = inst[17:16]), B1 = inst[15:8], B2 = inst[7:0]}
  - CSUM
- Checksum: 8-bit sum of every byte after SYNC, including CSUM, must equal 8'h00. Unused upper bits of ADDR_HI and B0 are still summed.
- States and transitions:
  - IDLE: non-SYNC bytes discarded; SYNC → ADDR_HI, clears load_err and checksum.
  - ADDR_HI → ADDR_LO → CNT_HI → CNT_LO: one byte each.
  - CNT_LO exit:
    - N > MAX_COUNT: set load_err, return to IDLE.
    - N == 0: go to CSUM.
    - Otherwise: go to B0.
  - B0 → B1 → B2 → WRITE.
  - WRITE: exactly one cycle, rx_ready=0, inst_update=1 with the assembled address and data.
    - Address then increments modulo 1024 (0x3FF wraps to 0x000).
    - Remaining count decrements.
    - Next state: remaining==0 → CSUM, else B0.
  - CSUM, after summing the byte:
    - Sum==0: toggle remap, pulse load_done for 1 cycle, go to IDLE.
    - Sum!=0: set load_err, remap unchanged, go to IDLE.
- Latency:
  - inst_update asserts the cycle after B2 is accepted.
  - remap/load_done update the cycle after CSUM is accepted.
- rx_ready is 1 in all states except WRITE. A byte presented during WRITE is held by the source, not dropped.
- Writes are committed as they arrive; a bad checksum does not undo them, it only suppresses the remap. The CPU keeps running the old mapping.
- SYNC_BYTE inside a frame is data, not a resync.
- Reset mid-frame: immediate return to IDLE, no further writes; remap returns to 0.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A 24-bit counter runs in any non-IDLE state and clears on each accepted byte.
  - Reaching TIMEOUT_CYCLES sets load_err and returns to IDLE; no remap toggle.
  - The counter does not run during WRITE.
- Undefined: no counter; the loader waits indefinitely for the next byte.

Test Plan:
- Good frame A5 00 10 00 02 01 23 45 03 FF FF 84 → two writes: addr 0x010 data 0x12345, addr 0x011 data 0x3FFFF. remap 0→1, load_done pulses once, load_err=0.
- Same frame with CSUM 85 → same two writes, remap stays 0, load_err=1. A following A5 clears load_err.
- Wrap: A5 03 FF 00 02 + two instructions + correct CSUM → writes at 0x3FF then 0x000.
- Count overflow: A5 00 00 04 01 → load_err=1, busy=0, no inst_update; next valid frame loads normally.
- rx_valid held continuously with back-to-back bytes → rx_ready low exactly one cycle per instruction (WRITE), no byte lost. Garbage 00 11 A4 before SYNC ignored.
- Reset asserted after the first B1 → no write; state IDLE; remap=0. With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100, stalling 100 cycles after CNT_HI → load_err=1, IDLE.
